// File: rtl/riscy_hps_pkg.sv
// riscy_hps_pkg: shared register map, STATUS bit positions and FSM states
// for the HPS-side Avalon-MM responder.
package riscy_hps_pkg;
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_MBOX_TX = 2'd2;
    localparam logic [1:0] REG_MBOX_RX = 2'd3;

    localparam int ST_TXV = 0;
    localparam int ST_RXV = 1;
    localparam int ST_RUN = 2;
    localparam int ST_OVF = 3;
    localparam int ST_TMO = 4;

    localparam logic [31:0] BAD_DATA = 32'hBAD0_0000;

    typedef enum logic [1:0] {IDLE, MEM_WAIT, MEM_DONE} state_t;
endpackage

// File: rtl/hps_mbox_slot.sv
// hps_mbox_slot: one-entry data/valid mailbox; a push into a full slot is
// dropped and flagged on overflow, and a push into an empty slot beats pop.
module hps_mbox_slot (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic [31:0] din,
    input  logic        pop,
    output logic [31:0] data,
    output logic        valid,
    output logic        overflow
);
    assign overflow = push && valid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (push && !valid) begin
            data  <= din;
            valid <= 1'b1;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/hps_avmm_responder.sv
// hps_avmm_responder: lightweight-bridge Avalon-MM responder giving the HPS
// riscy reset control, two mailboxes and a word window into riscy memory.
module hps_avmm_responder
    import riscy_hps_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int MEM_AW  = 14,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic              avs_waitrequest,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              core_rst_n,
    output logic [31:0]       to_core_data,
    output logic              to_core_valid,
    input  logic              to_core_ack,
    input  logic [31:0]       from_core_data,
    input  logic              from_core_valid,
    output logic              from_core_ack
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic          run, ovf, tmo, rdv;
    logic          mem_sel, req, reg_ok, ctrl_wr, ctrl_rd, status_wr;
    logic          tx_push, rx_take, tx_ovf, rx_ovf, timed_out;
    logic [1:0]    ofs;
    logic [31:0]   rd_reg, reg_rdata, status, fc_data;
    logic [CW-1:0] cnt;

    assign mem_sel   = avs_address[ADDR_W-1];
    assign req       = avs_read || avs_write;
    assign ofs       = avs_address[1:0];
    assign reg_ok    = avs_address[ADDR_W-2:2] == '0;
    assign ctrl_wr   = state == IDLE && !mem_sel && avs_write && reg_ok;
    assign ctrl_rd   = state == IDLE && !mem_sel && avs_read && !avs_write;
    assign status_wr = ctrl_wr && ofs == REG_STATUS;
    assign tx_push   = ctrl_wr && ofs == REG_MBOX_TX;
    assign rx_take   = ctrl_rd && reg_ok && ofs == REG_MBOX_RX && from_core_valid;
    assign timed_out = state == MEM_WAIT && !mem_ack && cnt == CW'(TIMEOUT - 1);

    assign avs_waitrequest   = !reset_reset_n || state == MEM_WAIT || (state == IDLE && req && mem_sel);
    assign avs_readdatavalid = rdv;
    // MBOX_RX data rides in the pop slot and is merged only during its ack pulse
    assign avs_readdata      = rd_reg | (from_core_ack ? fc_data : '0);
    assign core_rst_n        = run;

    always_comb begin
        status         = '0;
        status[ST_TXV] = to_core_valid;
        status[ST_RXV] = from_core_valid;
        status[ST_RUN] = run;
        status[ST_OVF] = ovf;
        status[ST_TMO] = tmo;
        reg_rdata = !reg_ok ? '0 : ofs == REG_CTRL ? {31'd0, run} : ofs == REG_STATUS ? status : '0;
    end

    hps_mbox_slot u_to_core (
        .clk(clk_clk), .reset_n(reset_reset_n), .push(tx_push), .din(avs_writedata),
        .pop(to_core_ack), .data(to_core_data), .valid(to_core_valid), .overflow(tx_ovf)
    );

    // Self-popping slot: a taken RX word lives for exactly one cycle, forming the ack pulse
    hps_mbox_slot u_from_core (
        .clk(clk_clk), .reset_n(reset_reset_n), .push(rx_take), .din(from_core_data),
        .pop(1'b1), .data(fc_data), .valid(from_core_ack), .overflow(rx_ovf)
    );

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state     <= IDLE;
            run       <= 1'b0;
            ovf       <= 1'b0;
            tmo       <= 1'b0;
            rdv       <= 1'b0;
            rd_reg    <= '0;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            rdv <= 1'b0;
            ovf <= tx_ovf || rx_ovf || (ovf && !(status_wr && avs_writedata[ST_OVF]));
            tmo <= timed_out || (tmo && !(status_wr && avs_writedata[ST_TMO]));
            if (ctrl_wr && ofs == REG_CTRL) run <= avs_writedata[0];
            case (state)
                IDLE: begin
                    if (req && mem_sel) begin
                        state     <= MEM_WAIT;
                        mem_req   <= 1'b1;
                        mem_we    <= avs_write;
                        mem_addr  <= avs_address[MEM_AW-1:0];
                        mem_wdata <= avs_writedata;
                        mem_be    <= avs_byteenable;
                        cnt       <= '0;
                    end else if (ctrl_rd) begin
                        rdv    <= 1'b1;
                        rd_reg <= reg_rdata;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        rd_reg  <= mem_rdata;
                        state   <= MEM_DONE;
                    end else if (timed_out) begin
                        mem_req <= 1'b0;
                        rd_reg  <= BAD_DATA;
                        state   <= MEM_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MEM_DONE: begin
                    rdv   <= !mem_we;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hps_avmm_responder.sv
// tb_hps_avmm_responder: vector table, directed corner sequences and a random
// phase checked against a register/memory model of the responder.
module tb_hps_avmm_responder;
    logic        clk = 1'b0;
    logic        reset_reset_n;
    logic [15:0] avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        mem_req, mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        core_rst_n;
    logic [31:0] to_core_data;
    logic        to_core_valid, to_core_ack;
    logic [31:0] from_core_data;
    logic        from_core_valid, from_core_ack;

    always #5 clk = ~clk;

    hps_avmm_responder dut (
        .clk_clk(clk), .reset_reset_n(reset_reset_n),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .core_rst_n(core_rst_n), .to_core_data(to_core_data), .to_core_valid(to_core_valid),
        .to_core_ack(to_core_ack), .from_core_data(from_core_data),
        .from_core_valid(from_core_valid), .from_core_ack(from_core_ack)
    );

    int errors = 0, checks = 0;
    logic [31:0] mem_arr [16384];
    logic [31:0] ref_arr [16384];
    int ack_delay = 1, req_cyc = 0, ack_pulses = 0;
    logic [13:0] last_addr = '0;
    logic [3:0]  last_be = '0;
    bit m_run, m_ovf, m_tmo, m_txv;
    logic [31:0] m_txd;

    typedef struct {
        logic [15:0] a;
        bit          rd;
        bit          wr;
        logic [31:0] wd;
        bit          rdv;
        logic [31:0] rdata;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory side: acks after ack_delay request cycles (0 = never), garbage rdata otherwise
    initial begin
        int w;
        w = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #3;
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (from_core_ack) ack_pulses++;
            if (mem_req) begin
                w++;
                req_cyc++;
                if (ack_delay != 0 && w == ack_delay) begin
                    mem_ack = 1'b1;
                    last_addr = mem_addr;
                    last_be = mem_be;
                    if (mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_be[b]) mem_arr[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
                    end else begin
                        mem_rdata = mem_arr[mem_addr];
                    end
                end
            end else begin
                w = 0;
            end
        end
    end

    task automatic access(input logic [15:0] a, input bit rd, input bit wr, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rdata, output bit rdv, output int acc);
        acc = 0;
        @(posedge clk); #1;
        avs_address = a; avs_read = rd; avs_write = wr; avs_writedata = wd; avs_byteenable = be;
        #1;
        while (avs_waitrequest && acc < 1000) begin
            @(posedge clk); #2;
            acc++;
        end
        if (avs_waitrequest) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: waitrequest high for %0d cycles, required low", acc);
        end
        @(posedge clk); #1;
        avs_read = 1'b0; avs_write = 1'b0;
        rdv = avs_readdatavalid;
        rdata = avs_readdata;
        #3;
    endtask

    task automatic mem_op(input bit wr, input bit hi, input logic [13:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input int dly);
        logic [31:0] rd;
        bit v;
        int acc;
        ack_delay = dly;
        req_cyc = 0;
        access({1'b1, hi, a}, !wr, wr, wd, be, rd, v, acc);
        chk("mem_req_cycles", 32'(req_cyc), 32'(dly));
        chk("mem_accept_cycle", 32'(acc), 32'(dly + 1));
        chk("mem_addr", 32'(last_addr), 32'(a));
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_arr[a][8*b +: 8] = wd[8*b +: 8];
            chk("mem_be", 32'(last_be), 32'(be));
            chk("mem_word", mem_arr[a], ref_arr[a]);
            chk("mem_wr_no_rdv", 32'(v), 32'd0);
        end else begin
            chk("mem_rd_rdv", 32'(v), 32'd1);
            chk("mem_rd_data", rd, ref_arr[a]);
        end
    endtask

    task automatic ctrl_op(input logic [15:0] a, input bit rd, input bit wr, input logic [31:0] wd);
        logic [31:0] got, exp;
        bit v, is_rd, known, pop;
        int acc, p0;
        is_rd = rd && !wr;
        known = a[15:2] == 14'd0;
        pop = is_rd && known && a[1:0] == 2'd3 && from_core_valid;
        exp = '0;
        if (is_rd && known) begin
            if (a[1:0] == 2'd0) exp = {31'd0, m_run};
            if (a[1:0] == 2'd1) exp = {27'd0, m_tmo, m_ovf, m_run, from_core_valid, m_txv};
            if (pop) exp = from_core_data;
        end
        p0 = ack_pulses;
        access(a, rd, wr, wd, 4'hF, got, v, acc);
        chk("ctrl_accept", 32'(acc), 32'd0);
        chk("ctrl_rdv", 32'(v), 32'(is_rd));
        if (is_rd) chk("ctrl_rdata", got, exp);
        chk("rx_ack_pulses", 32'(ack_pulses - p0), 32'(pop));
        if (pop) from_core_valid = 1'b0;
        if (wr && known) begin
            if (a[1:0] == 2'd0) m_run = wd[0];
            if (a[1:0] == 2'd1) begin
                if (wd[3]) m_ovf = 1'b0;
                if (wd[4]) m_tmo = 1'b0;
            end
            if (a[1:0] == 2'd2) begin
                if (m_txv) m_ovf = 1'b1;
                else begin m_txv = 1'b1; m_txd = wd; end
            end
        end
        chk("core_rst_n", 32'(core_rst_n), 32'(m_run));
        chk("to_core_valid", 32'(to_core_valid), 32'(m_txv));
        if (m_txv) chk("to_core_data", to_core_data, m_txd);
    endtask

    task automatic tc_ack();
        @(posedge clk); #1;
        to_core_ack = 1'b1;
        @(posedge clk); #1;
        to_core_ack = 1'b0;
        m_txv = 1'b0;
        chk("to_core_ack_clears", 32'(to_core_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        bit v;
        int acc, p0;
        logic [15:0] ra;
        int r, k;

        reset_reset_n = 1'b0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = '0; avs_byteenable = '0;
        to_core_ack = 1'b0; from_core_valid = 1'b0; from_core_data = '0;
        for (int i = 0; i < 16384; i++) begin
            mem_arr[i] = $urandom;
            ref_arr[i] = mem_arr[i];
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_waitrequest", 32'(avs_waitrequest), 32'd1);
        chk("rst_rdv", 32'(avs_readdatavalid), 32'd0);
        chk("rst_readdata", avs_readdata, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("rst_to_core_valid", 32'(to_core_valid), 32'd0);
        chk("rst_from_core_ack", 32'(from_core_ack), 32'd0);
        reset_reset_n = 1'b1;
        #1;
        chk("idle_waitrequest", 32'(avs_waitrequest), 32'd0);

        tbl[0]  = '{16'h0000, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 32'h0};
        tbl[1]  = '{16'h0001, 1'b1, 1'b0, 32'h0,         1'b1, 32'h4};
        tbl[2]  = '{16'h0002, 1'b0, 1'b1, 32'h0000_00A5, 1'b0, 32'h0};
        tbl[3]  = '{16'h0002, 1'b0, 1'b1, 32'h0000_00A5, 1'b0, 32'h0};
        tbl[4]  = '{16'h0001, 1'b1, 1'b0, 32'h0,         1'b1, 32'hD};
        tbl[5]  = '{16'h0001, 1'b0, 1'b1, 32'h0000_0008, 1'b0, 32'h0};
        tbl[6]  = '{16'h0001, 1'b1, 1'b0, 32'h0,         1'b1, 32'h5};
        tbl[7]  = '{16'h0005, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0};
        tbl[8]  = '{16'h0006, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0};
        tbl[9]  = '{16'h0000, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1};
        tbl[10] = '{16'h0000, 1'b1, 1'b1, 32'h0,         1'b0, 32'h0};
        tbl[11] = '{16'h0001, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1};
        tbl[12] = '{16'h0101, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0};
        tbl[13] = '{16'h0003, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0};
        for (int i = 0; i < 14; i++) begin
            access(tbl[i].a, tbl[i].rd, tbl[i].wr, tbl[i].wd, 4'hF, got, v, acc);
            chk($sformatf("vec%0d_rdv", i), 32'(v), 32'(tbl[i].rdv));
            if (tbl[i].rdv) chk($sformatf("vec%0d_rdata", i), got, tbl[i].rdata);
            if (i == 0) chk("ctrl_run_core_rst_n", 32'(core_rst_n), 32'd1);
        end
        chk("tx_data_kept_on_overflow", to_core_data, 32'hA5);
        tc_ack();

        // Ack arriving together with a write into an empty slot keeps the new word
        to_core_ack = 1'b1;
        access(16'h0002, 1'b0, 1'b1, 32'h0000_1234, 4'hF, got, v, acc);
        to_core_ack = 1'b0;
        chk("tx_ack_same_cycle_valid", 32'(to_core_valid), 32'd1);
        chk("tx_ack_same_cycle_data", to_core_data, 32'h1234);
        tc_ack();

        mem_op(1'b1, 1'b0, 14'h0010, 32'hCAFE_F00D, 4'h3, 4);
        mem_arr[14'h20] = 32'h1234_5678;
        ref_arr[14'h20] = 32'h1234_5678;
        mem_op(1'b0, 1'b0, 14'h0020, 32'h0, 4'hF, 1);

        from_core_valid = 1'b1;
        from_core_data = 32'h77;
        p0 = ack_pulses;
        access(16'h0003, 1'b1, 1'b0, 32'h0, 4'hF, got, v, acc);
        from_core_valid = 1'b0;
        chk("rx_full_data", got, 32'h77);
        chk("rx_full_pulse", 32'(ack_pulses - p0), 32'd1);
        p0 = ack_pulses;
        access(16'h0003, 1'b1, 1'b0, 32'h0, 4'hF, got, v, acc);
        chk("rx_empty_data", got, 32'h0);
        chk("rx_empty_rdv", 32'(v), 32'd1);
        chk("rx_empty_pulse", 32'(ack_pulses - p0), 32'd0);

        ack_delay = 0;
        req_cyc = 0;
        access(16'h8000, 1'b1, 1'b0, 32'h0, 4'hF, got, v, acc);
        chk("timeout_req_cycles", 32'(req_cyc), 32'd255);
        chk("timeout_accept", 32'(acc), 32'd256);
        chk("timeout_rdv", 32'(v), 32'd1);
        chk("timeout_data", got, 32'hBAD0_0000);
        access(16'h0001, 1'b1, 1'b0, 32'h0, 4'hF, got, v, acc);
        chk("status_tmo_set", 32'(got[4]), 32'd1);
        access(16'h0001, 1'b0, 1'b1, 32'h10, 4'hF, got, v, acc);
        access(16'h0001, 1'b1, 1'b0, 32'h0, 4'hF, got, v, acc);
        chk("status_tmo_cleared", 32'(got[4]), 32'd0);

        @(posedge clk); #1;
        avs_address = 16'h8003;
        avs_read = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midwait_mem_req", 32'(mem_req), 32'd1);
        reset_reset_n = 1'b0;
        @(posedge clk); #1;
        chk("reset_drops_mem_req", 32'(mem_req), 32'd0);
        chk("reset_waitrequest", 32'(avs_waitrequest), 32'd1);
        avs_read = 1'b0;
        @(posedge clk); #1;
        chk("reset_waitrequest_held", 32'(avs_waitrequest), 32'd1);
        chk("reset_no_rdv", 32'(avs_readdatavalid), 32'd0);
        reset_reset_n = 1'b1;
        #1;
        chk("post_reset_waitrequest", 32'(avs_waitrequest), 32'd0);
        m_run = 1'b0; m_ovf = 1'b0; m_tmo = 1'b0; m_txv = 1'b0; m_txd = '0;

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                mem_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 14'($urandom),
                       $urandom, 4'($urandom), $urandom_range(1, 6));
            end else if (r < 9) begin
                if (!from_core_valid && $urandom_range(0, 2) == 0) begin
                    from_core_valid = 1'b1;
                    from_core_data = $urandom;
                end
                ra = 16'($urandom_range(0, 5));
                if ($urandom_range(0, 7) == 0) ra[12] = 1'b1;
                k = $urandom_range(0, 4);
                ctrl_op(ra, k < 2 || k == 4, k >= 2, $urandom);
            end else begin
                tc_ack();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
